// File: rtl/hsst_rst_pkg.sv
// hsst_rst_pkg
//   Shared definitions for the HSST/PCIe reset-request initiator:
//   state encoding and the shortened constants used by the simulation
//   speedup build (IPSL_PCIE_SPEEDUP_SIM_EN).
package hsst_rst_pkg;

    localparam logic [1:0] ASSERT    = 2'd0;
    localparam logic [1:0] WAIT_DONE = 2'd1;
    localparam logic [1:0] RUN       = 2'd2;
    localparam logic [1:0] FAIL      = 2'd3;

    typedef enum logic [1:0] {
        ST_ASSERT    = ASSERT,
        ST_WAIT_DONE = WAIT_DONE,
        ST_RUN       = RUN,
        ST_FAIL      = FAIL
    } rst_state_e;

    localparam logic [15:0] SIM_TIMEOUT_VALUE = 16'h0040;
    localparam int unsigned SIM_LOCK_DEB      = 4;

endpackage

// File: rtl/hsst_rst_done_sync.sv
// hsst_rst_done_sync
//   Two-flop synchronizer for the asynchronous far-end reset-done flag.
//   Both stages clear to 0 while rstn is low, so a fresh sequence never
//   sees a stale "done" left over from before the block reset.
// Ports:
//   clk    in  PIPE-domain clock
//   rstn   in  synchronous active-low clear
//   d_in   in  asynchronous input
//   d_out  out synchronized output (two clk cycles of latency)
module hsst_rst_done_sync (
    input  logic clk,
    input  logic rstn,
    input  logic d_in,
    output logic d_out
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d_in;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign d_out = sync_q;

endmodule

// File: rtl/hsst_rst_req_gen_v1_0.sv
// hsst_rst_req_gen_v1_0
//   Reset-request initiator for the HSST/PCIe reset path. Drives an
//   active-low reset request to the far-end reset synchronizer and waits
//   for its reset-done. A reset is issued on block reset, debounced loss
//   of lock, a software request, or the far end dropping done; a missing
//   done is retried on timeout up to MAX_RETRY attempts, then FAIL.
//
//   Build option: define IPSL_PCIE_SPEEDUP_SIM_EN to replace the timeout
//   and lock debounce with short simulation-only values.
//
// Ports:
//   clk           in   PIPE-domain clock
//   rstn          in   synchronous active-low block reset
//   lock_in       in   PLL/CDR lock (already in clk domain)
//   rst_done_in   in   far-end reset-done (asynchronous)
//   soft_rst_req  in   single-cycle software reset request
//   rstn_req_out  out  registered active-low reset request
//   busy          out  high in every state except RUN
//   fail          out  high in FAIL
//   retry_cnt     out  timed-out attempts in the current sequence
module hsst_rst_req_gen_v1_0
    import hsst_rst_pkg::*;
#(
    parameter int unsigned              PULSE_CYCLES    = 16,
    parameter int unsigned              LOCK_DEB_CYCLES = 64,
    parameter int unsigned              TIMEOUT_W       = 16,
    parameter logic [TIMEOUT_W-1:0]     TIMEOUT_VALUE   = 16'hC000,
    parameter int unsigned              MAX_RETRY       = 3,
    parameter int unsigned              RETRY_W         = 2
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               lock_in,
    input  logic               rst_done_in,
    input  logic               soft_rst_req,
    output logic               rstn_req_out,
    output logic               busy,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_cnt
);

`ifdef IPSL_PCIE_SPEEDUP_SIM_EN
    localparam logic [TIMEOUT_W-1:0] TO_EFF  = TIMEOUT_W'(SIM_TIMEOUT_VALUE);
    localparam int unsigned          DEB_EFF = SIM_LOCK_DEB;
`else
    localparam logic [TIMEOUT_W-1:0] TO_EFF  = TIMEOUT_VALUE;
    localparam int unsigned          DEB_EFF = LOCK_DEB_CYCLES;
`endif

    localparam logic [7:0]         PULSE_LAST = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0]         DEB_LAST   = 8'(DEB_EFF - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);

    logic done_s;

    hsst_rst_done_sync u_done_sync (
        .clk   (clk),
        .rstn  (rstn),
        .d_in  (rst_done_in),
        .d_out (done_s)
    );

    rst_state_e           state_q, state_d;
    logic [7:0]           pulse_cnt_q, pulse_cnt_d;
    logic [7:0]           deb_cnt_q, deb_cnt_d;
    logic [TIMEOUT_W-1:0] to_cnt_q, to_cnt_d;
    logic [RETRY_W-1:0]   retry_cnt_q, retry_cnt_d;
    logic                 seen_low_q, seen_low_d;
    logic                 done_prev_q, done_prev_d;
    logic                 rstn_req_q, rstn_req_d;
    logic                 busy_q, busy_d;
    logic                 fail_q, fail_d;
    logic                 enter_assert;

    always_comb begin
        state_d      = state_q;
        pulse_cnt_d  = pulse_cnt_q;
        deb_cnt_d    = 8'd0;
        to_cnt_d     = to_cnt_q;
        retry_cnt_d  = retry_cnt_q;
        seen_low_d   = seen_low_q;
        done_prev_d  = done_s;
        enter_assert = 1'b0;

        case (state_q)
            ST_ASSERT: begin
                pulse_cnt_d = pulse_cnt_q + 8'd1;
                to_cnt_d    = '0;
                // A done that was never observed low belongs to an older
                // reset and must not complete this one.
                if (!done_s) seen_low_d = 1'b1;
                if (pulse_cnt_q == PULSE_LAST) begin
                    state_d     = ST_WAIT_DONE;
                    pulse_cnt_d = 8'd0;
                end
            end
            ST_WAIT_DONE: begin
                if (to_cnt_q != TO_EFF) to_cnt_d = to_cnt_q + 1'b1;
                if (!done_s) seen_low_d = 1'b1;
                if (done_s && seen_low_q) begin
                    state_d     = ST_RUN;
                    retry_cnt_d = '0;
                end else if (to_cnt_q == TO_EFF) begin
                    retry_cnt_d = retry_cnt_q + 1'b1;
                    if (retry_cnt_q == RETRY_LAST) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d      = ST_ASSERT;
                        enter_assert = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                deb_cnt_d = lock_in ? 8'd0 : deb_cnt_q + 8'd1;
                if ((!lock_in && deb_cnt_q == DEB_LAST) || (done_prev_q && !done_s)) begin
                    state_d      = ST_ASSERT;
                    retry_cnt_d  = '0;
                    enter_assert = 1'b1;
                end
            end
            ST_FAIL: begin
                to_cnt_d = '0;
            end
            default: begin
                state_d      = ST_ASSERT;
                enter_assert = 1'b1;
            end
        endcase

        // Software request outranks timeout, debounce and done detection.
        if (soft_rst_req) begin
            state_d      = ST_ASSERT;
            retry_cnt_d  = '0;
            enter_assert = 1'b1;
        end

        if (enter_assert) begin
            pulse_cnt_d = 8'd0;
            seen_low_d  = 1'b0;
            deb_cnt_d   = 8'd0;
            to_cnt_d    = '0;
        end

        // Outputs are decoded from the next state so they line up with it.
        rstn_req_d = (state_d == ST_WAIT_DONE) || (state_d == ST_RUN);
        busy_d     = (state_d != ST_RUN);
        fail_d     = (state_d == ST_FAIL);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_ASSERT;
            pulse_cnt_q <= 8'd0;
            deb_cnt_q   <= 8'd0;
            to_cnt_q    <= '0;
            retry_cnt_q <= '0;
            seen_low_q  <= 1'b0;
            done_prev_q <= 1'b0;
            rstn_req_q  <= 1'b0;
            busy_q      <= 1'b1;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pulse_cnt_q <= pulse_cnt_d;
            deb_cnt_q   <= deb_cnt_d;
            to_cnt_q    <= to_cnt_d;
            retry_cnt_q <= retry_cnt_d;
            seen_low_q  <= seen_low_d;
            done_prev_q <= done_prev_d;
            rstn_req_q  <= rstn_req_d;
            busy_q      <= busy_d;
            fail_q      <= fail_d;
        end
    end

    assign rstn_req_out = rstn_req_q;
    assign busy         = busy_q;
    assign fail         = fail_q;
    assign retry_cnt    = retry_cnt_q;

endmodule
